dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Multi-cycle data-memory responder for the CPU datapath's load/store
// requests. It holds a byte-addressed, big-endian store and services word
// and halfword accesses after a fixed number of wait states. Requests and
// responses each use a valid/ready handshake.
//
// Parameters:
//   ADDR_WIDTH  - byte-address bits implemented (memory is 2^ADDR_WIDTH bytes)
//   WAIT_STATES - cycles spent in WAIT per access (0..15)
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   req_valid  - request present
//   req_ready  - responder can accept (high only in IDLE)
//   req_write  - 1 = store, 0 = load
//   req_size   - 1 word, 2 halfword signed, 3 halfword unsigned, 0 illegal
//   req_addr   - byte address
//   req_wdata  - store data (halfword stores use [15:0])
//   rsp_valid  - response present
//   rsp_ready  - consumer accepts response
//   rsp_rdata  - load result (0 for stores and errors)
//   rsp_err    - request faulted
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   Defined   : misaligned word/halfword accesses fault.
//   Undefined : misaligned accesses run byte-wise big-endian from addr.
//
// Memory contents are not affected by reset.

module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int MEM_BYTES = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_mem [MEM_BYTES];

    logic                  w_accept;
    logic                  w_doAccess;
    logic                  w_opWrite;
    logic [1:0]            w_opSize;
    logic [31:0]           w_opAddr;
    logic [31:0]           w_opWdata;
    logic [ADDR_WIDTH-1:0] w_idx0;
    logic [ADDR_WIDTH-1:0] w_idx1;
    logic [ADDR_WIDTH-1:0] w_idx2;
    logic [ADDR_WIDTH-1:0] w_idx3;
    logic [ADDR_WIDTH:0]   w_lastLow;
    logic                  w_outOfRange;
    logic                  w_misalign;
    logic                  w_err;
    logic [31:0]           w_loadData;
    logic [31:0]           w_rdataNext;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // With zero wait states the access happens on the acceptance edge, so
    // the request inputs feed the access logic directly in that case.
    assign w_doAccess = reset &&
                        (((r_state == S_IDLE) && w_accept && (WAIT_STATES == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt <= 4'd1)));

    assign w_opWrite = (r_state == S_IDLE) ? req_write : r_write;
    assign w_opSize  = (r_state == S_IDLE) ? req_size  : r_size;
    assign w_opAddr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_opWdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_idx0 = w_opAddr[ADDR_WIDTH-1:0];
    assign w_idx1 = w_opAddr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    assign w_idx2 = w_opAddr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);
    assign w_idx3 = w_opAddr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(3);

    // The extra top bit catches the last byte running past the end of memory.
    assign w_lastLow = {1'b0, w_opAddr[ADDR_WIDTH-1:0]} +
                       ((w_opSize == 2'd1) ? (ADDR_WIDTH+1)'(3) : (ADDR_WIDTH+1)'(1));

    assign w_outOfRange = (w_opAddr[31:ADDR_WIDTH] != '0) || w_lastLow[ADDR_WIDTH];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_opSize == 2'd1) && (w_opAddr[1:0] != 2'b00)) ||
                        (w_opSize[1] && w_opAddr[0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (w_opSize == 2'd0) || w_outOfRange || w_misalign;

    always_comb begin
        w_loadData = 32'd0;
        case (w_opSize)
            2'd1:    w_loadData = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
            2'd2:    w_loadData = {{16{r_mem[w_idx0][7]}}, r_mem[w_idx0], r_mem[w_idx1]};
            2'd3:    w_loadData = {16'd0, r_mem[w_idx0], r_mem[w_idx1]};
            default: w_loadData = 32'd0;
        endcase
    end

    assign w_rdataNext = (w_err || w_opWrite) ? 32'd0 : w_loadData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= 4'(WAIT_STATES);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_doAccess) begin
                r_rdata <= w_rdataNext;
                r_err   <= w_err;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset; a store commits only on the RESP-entry edge, and
    // reset forces IDLE so a pending store can never land.
    always_ff @(posedge clk) begin
        if (w_doAccess && w_opWrite && !w_err) begin
            if (w_opSize == 2'd1) begin
                r_mem[w_idx0] <= w_opWdata[31:24];
                r_mem[w_idx1] <= w_opWdata[23:16];
                r_mem[w_idx2] <= w_opWdata[15:8];
                r_mem[w_idx3] <= w_opWdata[7:0];
            end else begin
                r_mem[w_idx0] <= w_opWdata[15:8];
                r_mem[w_idx1] <= w_opWdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Two instances are exercised: index 0 with
// two wait states, index 1 with zero wait states. Expected results come from
// a byte-array model of the memory.

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWrite  [2];
    logic [1:0]  reqSize   [2];
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic        rspValid  [2];
    logic        rspReady  [2];
    logic [31:0] rspRdata  [2];
    logic        rspErr    [2];

    int checks   = 0;
    int failures = 0;

    byte unsigned modelMem [2][1024];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
        .req_size(reqSize[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
        .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
        .req_size(reqSize[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
        .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
    );

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Reference behaviour: bounds, size and alignment rules, then big-endian
    // byte access into the model array.
    task automatic modelAccess(input int d, input logic wr, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rd, output logic er);
        longint a = longint'(addr);
        int     n = (sz == 2'd1) ? 4 : 2;
        longint val = 0;
        er = (sz == 2'd0) || (a + n > 1024);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (sz != 2'd0 && (a % n) != 0) er = 1'b1;
`endif
        rd = 32'd0;
        if (!er) begin
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    modelMem[d][int'(a) + k] = 8'((wdata >> (8 * (n - 1 - k))) & 32'hFF);
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    val = val * 256 + longint'(modelMem[d][int'(a) + k]);
                end
                if (sz == 2'd2 && val >= 32768) val = val - 65536;
                rd = 32'(val);
            end
        end
    endtask

    task automatic applyStimulus(input int d, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold);
        logic [31:0] expRd;
        logic        expErr;
        int          lat;
        reqValid[d] = 1'b1;
        reqWrite[d] = wr;
        reqSize[d]  = sz;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        rspReady[d] = (hold == 0);
        checkOutput("req_ready_idle", 32'(reqReady[d]), 32'd1);
        @(posedge clk);
        modelAccess(d, wr, sz, addr, wdata, expRd, expErr);
        @(negedge clk);
        lat = 1;
        reqValid[d] = 1'b0;
        reqWrite[d] = 1'($urandom_range(0, 1));
        reqSize[d]  = 2'($urandom_range(0, 3));
        reqAddr[d]  = $urandom;
        reqWdata[d] = $urandom;
        while (rspValid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(waitOf(d) + 1));
        checkOutput("rsp_rdata", rspRdata[d], expRd);
        checkOutput("rsp_err", 32'(rspErr[d]), 32'(expErr));
        checkOutput("req_ready_busy", 32'(reqReady[d]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("bp_rdata", rspRdata[d], expRd);
            checkOutput("bp_err", 32'(rspErr[d]), 32'(expErr));
            checkOutput("bp_req_ready", 32'(reqReady[d]), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rspValid[d]), 32'd1);
        end
        rspReady[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_req_ready", 32'(reqReady[d]), 32'd1);
        checkOutput("post_rsp_valid", 32'(rspValid[d]), 32'd0);
        checkOutput("post_rdata", rspRdata[d], 32'd0);
        checkOutput("post_err", 32'(rspErr[d]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] expRd;
        logic        expErr;
        logic [31:0] addr;
        logic [1:0]  sz;
        int          accepts;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqSize[d] = 2'd0;
            reqAddr[d] = 32'd0; reqWdata[d] = 32'd0; rspReady[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_req_ready", 32'(reqReady[d]), 32'd1);
            checkOutput("reset_rsp_valid", 32'(rspValid[d]), 32'd0);
            checkOutput("reset_rdata", rspRdata[d], 32'd0);
            checkOutput("reset_err", 32'(rspErr[d]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Give every byte of both memories a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 256; w++) begin
                applyStimulus(d, 1'b1, 2'd1, 32'(w * 4), $urandom, 0);
            end
        end

        // Word store then load.
        applyStimulus(0, 1'b1, 2'd1, 32'h10, 32'hDEADBEEF, 0);
        applyStimulus(0, 1'b0, 2'd1, 32'h10, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'd3, 32'h10, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'd3, 32'h12, 32'h0, 0);

        // Halfword sign handling.
        applyStimulus(0, 1'b1, 2'd1, 32'h20, 32'h80017FFF, 0);
        applyStimulus(0, 1'b0, 2'd2, 32'h20, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'd3, 32'h20, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'd2, 32'h22, 32'h0, 0);

        // Back-pressure.
        applyStimulus(0, 1'b0, 2'd1, 32'h20, 32'h0, 5);

        // Errors and misaligned store.
        applyStimulus(0, 1'b0, 2'd0, 32'h10, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'd1, 32'h3FE, 32'h0, 0);
        applyStimulus(0, 1'b1, 2'd1, 32'h5, 32'hA1B2C3D4, 0);
        applyStimulus(0, 1'b0, 2'd1, 32'h4, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'd1, 32'h8, 32'h0, 0);
        applyStimulus(1, 1'b1, 2'd2, 32'h1000, 32'h1234, 1);

        // Reset while a store is in WAIT: the model never sees this store.
        reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqSize[0] = 2'd1;
        reqAddr[0] = 32'h40; reqWdata[0] = 32'h12345678; rspReady[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_wait_req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("rst_wait_rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("rst_wait_rdata", rspRdata[0], 32'd0);
        checkOutput("rst_wait_err", 32'(rspErr[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1'b0, 2'd1, 32'h40, 32'h0, 0);

        // Zero wait states, back-to-back loads with rsp_ready held high.
        modelAccess(1, 1'b0, 2'd1, 32'h80, 32'h0, expRd, expErr);
        reqValid[1] = 1'b1; reqWrite[1] = 1'b0; reqSize[1] = 2'd1;
        reqAddr[1] = 32'h80; rspReady[1] = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("tput_req_ready", 32'(reqReady[1]), 32'((i % 2) == 0));
            checkOutput("tput_rsp_valid", 32'(rspValid[1]), 32'((i % 2) == 1));
            if (reqReady[1] === 1'b1) accepts++;
            else checkOutput("tput_rdata", rspRdata[1], expRd);
            @(posedge clk);
            @(negedge clk);
        end
        reqValid[1] = 1'b0;
        checkOutput("tput_accepts", 32'(accepts), 32'd4);
        @(negedge clk);

        // Randomized traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) addr = (sz == 2'd1) ? (addr & 32'h3FC) : (addr & 32'h3FE);
            if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(10, 31));
            applyStimulus(i % 2, 1'($urandom_range(0, 1)), sz, addr, $urandom,
                          int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
